// File: rtl/fast_pat_load.sv
`default_nettype none
// ============================================================================
//  Module   : fast_pat_load
//  Purpose  : Packs a 24-bit RGB pixel stream, 32 pixels per group, into three
//             256-bit words and writes them to the on-chip pattern memory
//             starting at BASE_ADDR. The header word is cleared before any data
//             is written and gets MAGIC only after the last data word is
//             accepted, so the fetch side never sees a partial pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module fast_pat_load #(
  parameter int         ADDR_W     = 11,
  parameter int         DATA_W     = 256,
  parameter int         PIX_W      = 24,
  parameter int         HDR_ADDR   = 0,
  parameter int         BASE_ADDR  = 1,
  parameter logic [7:0] MAGIC      = 8'h77,
  parameter int         MAX_GROUPS = 682
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [9:0]          group_num,
  input  logic [PIX_W-1:0]    pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic                onchip_mem_chip_select,
  output logic                onchip_mem_chip_read,
  output logic                onchip_mem_write,
  output logic [ADDR_W-1:0]   onchip_mem_addr,
  output logic [DATA_W/8-1:0] onchip_mem_byte_enable,
  output logic [DATA_W-1:0]   onchip_mem_write_data,
  input  logic                onchip_mem_waitrequest,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR_HDR = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_SET_HDR = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [9:0]            r_remaining;
  logic [ADDR_W-1:0]     r_addr;
  logic [4:0]            r_idx;
  logic [1:0]            r_wsel;
  logic [3*DATA_W-1:0]   r_pack;
  logic                  r_done;
  logic                  r_err;

  logic                  w_legal;
  logic                  w_pix_acc;
  logic                  w_wr;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [9:0]            w_msb;

  assign w_legal   = (group_num != 10'd0) && (group_num <= 10'(MAX_GROUPS));
  assign w_pix_acc = (r_state == S_COLLECT) && pix_valid;
  // Pixel k occupies pack[767-24k -: 24], so pixel 0 ends up in the MSBs.
  assign w_msb     = 10'(3*DATA_W-1) - (10'(PIX_W) * 10'(r_idx));

  // Next-state decode and memory-port drive; all write outputs idle to 0.
  always_comb begin
    w_next  = r_state;
    w_wr    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start && w_legal) w_next = S_CLR_HDR;
      end
      S_CLR_HDR: begin
        w_wr   = 1'b1;
        w_addr = ADDR_W'(HDR_ADDR);
        if (!onchip_mem_waitrequest) w_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_pix_acc && (r_idx == 5'd31)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_wr   = 1'b1;
        w_addr = r_addr;
        case (r_wsel)
          2'd0:    w_wdata = r_pack[3*DATA_W-1:2*DATA_W];
          2'd1:    w_wdata = r_pack[2*DATA_W-1:DATA_W];
          default: w_wdata = r_pack[DATA_W-1:0];
        endcase
        if (!onchip_mem_waitrequest && (r_wsel == 2'd2))
          w_next = (r_remaining == 10'd1) ? S_SET_HDR : S_COLLECT;
      end
      S_SET_HDR: begin
        w_wr    = 1'b1;
        w_addr  = ADDR_W'(HDR_ADDR);
        w_wdata = {{(DATA_W-8){1'b0}}, MAGIC};
        if (!onchip_mem_waitrequest) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and the one-cycle done/err status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_SET_HDR) && !onchip_mem_waitrequest;
      r_err   <= (r_state == S_IDLE) && start && !w_legal;
    end
  end

  // Group counter, data address pointer and word selector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_addr      <= '0;
      r_wsel      <= '0;
    end else begin
      if ((r_state == S_IDLE) && start && w_legal)
        r_remaining <= group_num;
      if ((r_state == S_CLR_HDR) && !onchip_mem_waitrequest)
        r_addr <= ADDR_W'(BASE_ADDR);
      if ((r_state == S_WRITE) && !onchip_mem_waitrequest) begin
        r_addr <= r_addr + 1'b1;
        if (r_wsel == 2'd2) begin
          r_wsel      <= 2'd0;
          r_remaining <= r_remaining - 1'b1;
        end else begin
          r_wsel <= r_wsel + 1'b1;
        end
      end
    end
  end

  // Pack register fill; the 5-bit index wraps to 0 after pixel 31.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pack <= '0;
      r_idx  <= '0;
    end else if (w_pix_acc) begin
      r_pack[w_msb -: PIX_W] <= pix_data;
      r_idx                  <= r_idx + 1'b1;
    end
  end

  assign pix_ready              = (r_state == S_COLLECT);
  assign onchip_mem_chip_select = w_wr;
  assign onchip_mem_chip_read   = 1'b0;
  assign onchip_mem_write       = w_wr;
  assign onchip_mem_addr        = w_addr;
  assign onchip_mem_byte_enable = {(DATA_W/8){w_wr}};
  assign onchip_mem_write_data  = w_wdata;
  assign busy                   = (r_state != S_IDLE);
  assign done                   = r_done;
  assign err                    = r_err;

endmodule
`default_nettype wire
